// File: rtl/fhe_cmd_pkg.sv
// Shared definitions for the command dispatcher: opcodes, command layout
// and the dispatcher state encoding.
package fhe_cmd_pkg;

  localparam int unsigned CMD_W = 64;

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_BARRIER = 8'hFF;

  // Field positions: [63:56] opcode, [55:52] slot, [51:48] core, [47:0] addr
  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  slot;
    logic [3:0]  core;
    logic [47:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BARRIER = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with combinational head read; caller must not push
// when full nor pop when empty.
module cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/cmd_dispatcher.sv
// In-order command dispatcher: pops 64-bit commands from a FIFO and issues
// them as one-hot pulses to engine cores, with barrier and halt handling.
module cmd_dispatcher
  import fhe_cmd_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [63:0]          in_cmd,
  output logic                 in_ready,
  output logic [NUM_CORES-1:0] cmd_valid,
  output logic [7:0]           cmd_opcode,
  output logic [3:0]           cmd_slot,
  output logic [47:0]          cmd_dma_addr,
  input  logic [NUM_CORES-1:0] engine_ready,
  output logic                 halted,
  output logic                 bad_core,
  output logic [31:0]          dispatch_count,
  output logic [1:0]           dbg_state
);

  localparam logic [4:0] NC = 5'(NUM_CORES);

  state_t               state_q, state_d;
  logic [CMD_W-1:0]     fifo_head;
  cmd_t                 head;
  logic                 fifo_full, fifo_empty, push, pop;
  logic                 dispatch, drop, take_barrier, take_halt, all_idle;
  logic                 tgt_ok;
  logic [NUM_CORES-1:0] tgt_hot;

  logic [NUM_CORES-1:0] cmd_valid_q;
  logic [7:0]           opcode_q;
  logic [3:0]           slot_q;
  logic [47:0]          addr_q;
  logic                 bad_q;
  logic [31:0]          count_q;

  assign in_ready = !rst && !fifo_full && (state_q == ST_RUN || state_q == ST_BARRIER);
  assign push     = in_valid && in_ready;
  assign head     = cmd_t'(fifo_head);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_cmd),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (take_halt) state_d = ST_DRAIN;
                  else if (take_barrier) state_d = ST_BARRIER;
      ST_BARRIER: if (all_idle) state_d = ST_RUN;
      ST_DRAIN:   if (all_idle) state_d = ST_HALTED;
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_RUN;
    endcase
  end

  // A core that was pulsed last cycle is exactly the bits of cmd_valid_q,
  // so the registered pulse doubles as the one-cycle block flag.
  always_comb begin
    tgt_hot = '0;
    tgt_ok  = 1'b0;
    for (int unsigned k = 0; k < unsigned'(NUM_CORES); k++) begin
      if (head.core == 4'(k)) begin
        tgt_hot[k] = 1'b1;
        tgt_ok     = engine_ready[k] && !cmd_valid_q[k];
      end
    end
    take_halt    = (state_q == ST_RUN) && !fifo_empty && (head.opcode == OP_HALT);
    take_barrier = (state_q == ST_RUN) && !fifo_empty && (head.opcode == OP_BARRIER);
    dispatch     = (state_q == ST_RUN) && !fifo_empty && !take_halt && !take_barrier &&
                   ({1'b0, head.core} < NC) && tgt_ok;
    drop         = (state_q == ST_RUN) && !fifo_empty && !take_halt && !take_barrier &&
                   ({1'b0, head.core} >= NC);
    pop          = dispatch || drop || take_halt || take_barrier;
    all_idle     = (&engine_ready) && !(|cmd_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= '0;
      opcode_q    <= '0;
      slot_q      <= '0;
      addr_q      <= '0;
      bad_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      cmd_valid_q <= dispatch ? tgt_hot : '0;
      bad_q       <= drop;
      if (dispatch) begin
        opcode_q <= head.opcode;
        slot_q   <= head.slot;
        addr_q   <= head.addr;
        count_q  <= count_q + 32'd1;
      end
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_opcode     = opcode_q;
  assign cmd_slot       = slot_q;
  assign cmd_dma_addr   = addr_q;
  assign bad_core       = bad_q;
  assign dispatch_count = count_q;
  assign halted         = (state_q == ST_HALTED);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher (NUM_CORES=2, FIFO_DEPTH=4): per-cycle
// vector table plus hand-written sequences for full FIFO, halt and reset.
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_cmd;
  logic        in_ready;
  logic [1:0]  cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic [1:0]  engine_ready;
  logic        halted;
  logic        bad_core;
  logic [31:0] dispatch_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_dispatcher #(.NUM_CORES(2), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_cmd         (in_cmd),
    .in_ready       (in_ready),
    .cmd_valid      (cmd_valid),
    .cmd_opcode     (cmd_opcode),
    .cmd_slot       (cmd_slot),
    .cmd_dma_addr   (cmd_dma_addr),
    .engine_ready   (engine_ready),
    .halted         (halted),
    .bad_core       (bad_core),
    .dispatch_count (dispatch_count),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] cmd;
    logic [1:0]  er;
    logic [1:0]  cv;
    logic [7:0]  op;
    logic [3:0]  sl;
    logic [47:0] ad;
    logic [31:0] cnt;
    logic        bad;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] C(input logic [7:0] op, input logic [3:0] slot,
                                    input logic [3:0] core, input logic [47:0] a);
    return {op, slot, core, a};
  endfunction

  function automatic vec_t V(input logic iv, input logic [63:0] cmd, input logic [1:0] er,
                             input logic [1:0] cv, input logic [7:0] op, input logic [3:0] sl,
                             input logic [47:0] ad, input logic [31:0] cnt, input logic bad,
                             input logic [1:0] st);
    vec_t r;
    r.iv = iv; r.cmd = cmd; r.er = er; r.cv = cv; r.op = op; r.sl = sl;
    r.ad = ad; r.cnt = cnt; r.bad = bad; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single dispatch
    tbl.push_back(V(1, C(8'h10, 4'h0, 4'h0, 48'h1234), 2'b11, 2'b00, 8'h00, 4'h0, 48'h0,    0, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b01, 8'h10, 4'h0, 48'h1234, 1, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,    1, 0, 0));
    // Head for not-ready core 1 stalls the core-0 command behind it
    tbl.push_back(V(1, C(8'h20, 4'h1, 4'h1, 48'h100), 2'b01, 2'b00, 8'h00, 4'h0, 48'h0,   1, 0, 0));
    tbl.push_back(V(1, C(8'h21, 4'h2, 4'h0, 48'h200), 2'b01, 2'b00, 8'h00, 4'h0, 48'h0,   1, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b01, 2'b00, 8'h00, 4'h0, 48'h0,   1, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b10, 8'h20, 4'h1, 48'h100, 2, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b01, 8'h21, 4'h2, 48'h200, 3, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 0));
    // Out-of-range core id is dropped
    tbl.push_back(V(1, C(8'h30, 4'h0, 4'h5, 48'h300), 2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   3, 1, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 0));
    // Barrier waits for all engines ready
    tbl.push_back(V(1, C(8'hFF, 4'h0, 4'h0, 48'h0),   2'b10, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 0));
    tbl.push_back(V(1, C(8'h40, 4'h3, 4'h1, 48'h400), 2'b10, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 1));
    tbl.push_back(V(0, 64'h0,                         2'b10, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 1));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   3, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b10, 8'h40, 4'h3, 48'h400, 4, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   4, 0, 0));
    // Same core twice: push during pop, then one-cycle block
    tbl.push_back(V(1, C(8'h60, 4'h0, 4'h0, 48'h600), 2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   4, 0, 0));
    tbl.push_back(V(1, C(8'h61, 4'h0, 4'h0, 48'h610), 2'b11, 2'b01, 8'h60, 4'h0, 48'h600, 5, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   5, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b01, 8'h61, 4'h0, 48'h610, 6, 0, 0));
    tbl.push_back(V(0, 64'h0,                         2'b11, 2'b00, 8'h00, 4'h0, 48'h0,   6, 0, 0));

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_cmd = '0; engine_ready = 2'b11;
    #2;
    chk("rst.cv", cmd_valid, 2'b00);
    chk("rst.rdy", in_ready, 1'b0);
    tick; tick;
    chk("rst.cnt", dispatch_count, 32'd0);
    chk("rst.halted", halted, 1'b0);
    chk("rst.bad", bad_core, 1'b0);
    chk("rst.st", dbg_state, 2'd0);
    chk("rst.op", cmd_opcode, 8'h00);
    chk("rst.addr", cmd_dma_addr, 48'h0);
    rst = 1'b0;
    #1;
    chk("rst.rdy_after", in_ready, 1'b1);

    foreach (tbl[i]) begin
      in_valid     = tbl[i].iv;
      in_cmd       = tbl[i].cmd;
      engine_ready = tbl[i].er;
      tick;
      chk($sformatf("v%0d.cv", i), cmd_valid, tbl[i].cv);
      chk($sformatf("v%0d.cnt", i), dispatch_count, tbl[i].cnt);
      chk($sformatf("v%0d.bad", i), bad_core, tbl[i].bad);
      chk($sformatf("v%0d.st", i), dbg_state, tbl[i].st);
      chk($sformatf("v%0d.rdy", i), in_ready, 1'b1);
      if (tbl[i].cv != 2'b00) begin
        chk($sformatf("v%0d.op", i), cmd_opcode, tbl[i].op);
        chk($sformatf("v%0d.slot", i), cmd_slot, tbl[i].sl);
        chk($sformatf("v%0d.addr", i), cmd_dma_addr, tbl[i].ad);
      end
    end

    // Fill the FIFO with all engines stalled, then drain in order
    engine_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_cmd   = C(8'(8'h51 + i), 4'h0, 4'(i % 2), 48'(48'h500 + i));
      tick;
      chk($sformatf("full.rdy%0d", i), in_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    in_cmd = C(8'h55, 4'h0, 4'h0, 48'h555);
    tick;
    chk("full.hold_rdy", in_ready, 1'b0);
    chk("full.hold_cv", cmd_valid, 2'b00);
    in_valid = 1'b0;
    engine_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("drain.cv%0d", i), cmd_valid, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("drain.op%0d", i), cmd_opcode, 8'(8'h51 + i));
      chk($sformatf("drain.cnt%0d", i), dispatch_count, 32'(7 + i));
      chk($sformatf("drain.rdy%0d", i), in_ready, 1'b1);
    end
    tick;
    chk("drain.extra_cv", cmd_valid, 2'b00);
    chk("drain.extra_cnt", dispatch_count, 32'd10);

    // Halt: following command is never dispatched
    in_valid = 1'b1;
    in_cmd   = C(8'h00, 4'h0, 4'h0, 48'h0);
    tick;
    chk("halt.st0", dbg_state, 2'd0);
    in_cmd = C(8'h70, 4'h0, 4'h0, 48'h700);
    tick;
    chk("halt.st_drain", dbg_state, 2'd2);
    chk("halt.rdy_drain", in_ready, 1'b0);
    in_valid = 1'b0;
    tick;
    chk("halt.st_halted", dbg_state, 2'd3);
    chk("halt.halted", halted, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("halt.cv%0d", i), cmd_valid, 2'b00);
      chk($sformatf("halt.sticky%0d", i), halted, 1'b1);
      chk($sformatf("halt.rdy%0d", i), in_ready, 1'b0);
      chk($sformatf("halt.cnt%0d", i), dispatch_count, 32'd10);
    end
    rst = 1'b1;
    #1;
    chk("halt.rst_halted", halted, 1'b0);
    chk("halt.rst_st", dbg_state, 2'd0);
    chk("halt.rst_rdy", in_ready, 1'b0);
    chk("halt.rst_cnt", dispatch_count, 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("halt.post_rdy", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("halt.post_cv%0d", i), cmd_valid, 2'b00);
    end

    // Latency from accept, then async reset mid-dispatch discards the queue
    in_valid = 1'b1;
    in_cmd   = C(8'h80, 4'h0, 4'h0, 48'h800);
    tick;
    chk("lat.cv_early", cmd_valid, 2'b00);
    in_cmd = C(8'h81, 4'h0, 4'h0, 48'h810);
    tick;
    chk("lat.cv", cmd_valid, 2'b01);
    chk("lat.op", cmd_opcode, 8'h80);
    chk("lat.cnt", dispatch_count, 32'd1);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst.cv", cmd_valid, 2'b00);
    chk("arst.op", cmd_opcode, 8'h00);
    chk("arst.cnt", dispatch_count, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("arst.post_cv%0d", i), cmd_valid, 2'b00);
      chk($sformatf("arst.post_cnt%0d", i), dispatch_count, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
